// File: rtl/execute.sv
// ---------------------------------------------------------------------------
// execute -- pipeline execute stage with ID/EX register, forwarding muxes,
// 32-bit ALU and a sequential 32x32->64 shift-add multiplier (HI/LO).
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   *D inputs           decode-stage controls, specifiers and data
//   ALUOutM, ResultW    forwarded values from memory / writeback stages
//   FlushE              loads zeros into every ID/EX register
//   ForwardAE/BE        operand forward selects (00/11 reg, 01 WB, 10 MEM)
//   jumpE..PCPlus4E     registered execute-stage controls and data
//   ALUMultOut          ALU result, or LO/HI selected by MemtoRegE
//   WriteDataE          forwarded second register operand (store data)
//   MultStartE          registered multiply start
//   MultDoneE           high while the multiplier is idle (HI/LO valid)
//   RsE, RtE, RdE       registered specifiers for the hazard unit
// ---------------------------------------------------------------------------
module execute (
  input  logic        clk,
  input  logic        rst,
  input  logic        MultStartD,
  input  logic        MultSgnD,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        BranchD,
  input  logic        RegDstD,
  input  logic        jumpD,
  input  logic [1:0]  ALUSrcD,
  input  logic [1:0]  MemtoRegD,
  input  logic [2:0]  ALUControlD,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RdD,
  input  logic [31:0] rd1D,
  input  logic [31:0] rd2D,
  input  logic [31:0] SignImmD,
  input  logic [31:0] UnsignedImmD,
  input  logic [31:0] PCPlus4D,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  output logic        jumpE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic [1:0]  MemtoRegE,
  output logic [4:0]  WriteRegE,
  output logic [31:0] ALUMultOut,
  output logic [31:0] WriteDataE,
  output logic [31:0] PCPlus4E,
  output logic        MultStartE,
  output logic        MultDoneE,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} multState_t;

  // ID/EX register contents that are not ports
  logic        multSgnE, branchE, regDstE;
  logic [1:0]  aluSrcE;
  logic [2:0]  aluControlE;
  logic [31:0] rd1E, rd2E, signImmE, unsignedImmE;

  // Branch is resolved outside this stage; the copy is kept but not consumed.
  logic unusedBranch;
  assign unusedBranch = branchE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      MultStartE   <= 1'b0;
      multSgnE     <= 1'b0;
      RegWriteE    <= 1'b0;
      MemWriteE    <= 1'b0;
      branchE      <= 1'b0;
      regDstE      <= 1'b0;
      jumpE        <= 1'b0;
      aluSrcE      <= 2'b00;
      MemtoRegE    <= 2'b00;
      aluControlE  <= 3'b000;
      RsE          <= 5'd0;
      RtE          <= 5'd0;
      RdE          <= 5'd0;
      rd1E         <= 32'd0;
      rd2E         <= 32'd0;
      signImmE     <= 32'd0;
      unsignedImmE <= 32'd0;
      PCPlus4E     <= 32'd0;
    end else begin
      MultStartE   <= MultStartD;
      multSgnE     <= MultSgnD;
      RegWriteE    <= RegWriteD;
      MemWriteE    <= MemWriteD;
      branchE      <= BranchD;
      regDstE      <= RegDstD;
      jumpE        <= jumpD;
      aluSrcE      <= ALUSrcD;
      MemtoRegE    <= MemtoRegD;
      aluControlE  <= ALUControlD;
      RsE          <= RsD;
      RtE          <= RtD;
      RdE          <= RdD;
      rd1E         <= rd1D;
      rd2E         <= rd2D;
      signImmE     <= SignImmD;
      unsignedImmE <= UnsignedImmD;
      PCPlus4E     <= PCPlus4D;
    end
  end

  // Operand forwarding and ALU
  logic [31:0] srcAE, srcBE, aluResult;

  always_comb begin
    srcAE      = rd1E;
    WriteDataE = rd2E;
    srcBE      = WriteDataE;
    aluResult  = 32'd0;
    case (ForwardAE)
      2'b01:   srcAE = ResultW;
      2'b10:   srcAE = ALUOutM;
      default: srcAE = rd1E;
    endcase
    case (ForwardBE)
      2'b01:   WriteDataE = ResultW;
      2'b10:   WriteDataE = ALUOutM;
      default: WriteDataE = rd2E;
    endcase
    case (aluSrcE)
      2'b01:   srcBE = signImmE;
      2'b10:   srcBE = unsignedImmE;
      2'b11:   srcBE = {unsignedImmE[15:0], 16'h0000};
      default: srcBE = WriteDataE;
    endcase
    case (aluControlE)
      3'b000:  aluResult = srcAE & srcBE;
      3'b001:  aluResult = srcAE | srcBE;
      3'b010:  aluResult = srcAE + srcBE;
      3'b011:  aluResult = srcAE ^ srcBE;
      3'b100:  aluResult = ~(srcAE | srcBE);
      3'b101:  aluResult = {31'd0, srcAE < srcBE};
      3'b110:  aluResult = srcAE - srcBE;
      default: aluResult = {31'd0, $signed(srcAE) < $signed(srcBE)};
    endcase
  end

  assign WriteRegE = regDstE ? RdE : RtE;

  // Multiplier: magnitudes are multiplied, sign applied to the 64-bit result
  multState_t  stateReg, stateNext;
  logic [63:0] mcandReg, accReg, accStep;
  logic [31:0] mplierReg, hiReg, loReg, magA, magB;
  logic [4:0]  countReg;
  logic        negReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (MultStartE) stateNext = BUSY;
      default: if (countReg == 5'd31) stateNext = IDLE;
    endcase
  end

  assign MultDoneE = (stateReg == IDLE);
  assign magA      = (multSgnE && srcAE[31])      ? -srcAE      : srcAE;
  assign magB      = (multSgnE && WriteDataE[31]) ? -WriteDataE : WriteDataE;
  assign accStep   = accReg + (mplierReg[0] ? mcandReg : 64'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcandReg  <= 64'd0;
      accReg    <= 64'd0;
      mplierReg <= 32'd0;
      countReg  <= 5'd0;
      negReg    <= 1'b0;
      hiReg     <= 32'd0;
      loReg     <= 32'd0;
    end else if (stateReg == IDLE) begin
      if (MultStartE) begin
        mcandReg  <= {32'd0, magA};
        mplierReg <= magB;
        accReg    <= 64'd0;
        countReg  <= 5'd0;
        negReg    <= multSgnE & (srcAE[31] ^ WriteDataE[31]);
      end
    end else begin
      accReg    <= accStep;
      mcandReg  <= mcandReg << 1;
      mplierReg <= mplierReg >> 1;
      countReg  <= countReg + 5'd1;
      if (countReg == 5'd31) begin
        {hiReg, loReg} <= negReg ? -accStep : accStep;
      end
    end
  end

  always_comb begin
    case (MemtoRegE)
      2'b10:   ALUMultOut = loReg;
      2'b11:   ALUMultOut = hiReg;
      default: ALUMultOut = aluResult;
    endcase
  end

endmodule

// File: tb/tb_execute.sv
// ---------------------------------------------------------------------------
// tb_execute -- directed self-checking bench for the execute stage.
// ---------------------------------------------------------------------------
module tb_execute;
  logic        clk = 1'b0;
  logic        rst;
  logic        MultStartD, MultSgnD, RegWriteD, MemWriteD, BranchD, RegDstD, jumpD;
  logic [1:0]  ALUSrcD, MemtoRegD;
  logic [2:0]  ALUControlD;
  logic [4:0]  RsD, RtD, RdD;
  logic [31:0] rd1D, rd2D, SignImmD, UnsignedImmD, PCPlus4D, ALUOutM, ResultW;
  logic        FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        jumpE, RegWriteE, MemWriteE, MultStartE, MultDoneE;
  logic [1:0]  MemtoRegE;
  logic [4:0]  WriteRegE, RsE, RtE, RdE;
  logic [31:0] ALUMultOut, WriteDataE, PCPlus4E;

  int nChecks = 0;
  int nFails  = 0;

  execute dut (
    .clk(clk), .rst(rst),
    .MultStartD(MultStartD), .MultSgnD(MultSgnD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .RegDstD(RegDstD), .jumpD(jumpD),
    .ALUSrcD(ALUSrcD), .MemtoRegD(MemtoRegD), .ALUControlD(ALUControlD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .rd1D(rd1D), .rd2D(rd2D), .SignImmD(SignImmD), .UnsignedImmD(UnsignedImmD),
    .PCPlus4D(PCPlus4D), .ALUOutM(ALUOutM), .ResultW(ResultW),
    .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .jumpE(jumpE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE), .ALUMultOut(ALUMultOut),
    .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .MultStartE(MultStartE),
    .MultDoneE(MultDoneE), .RsE(RsE), .RtE(RtE), .RdE(RdE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply from the decode stage; optionally flushes and pulses
  // start while the multiplier is busy, neither of which may disturb it.
  task automatic runMult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] prod, input bit disturb);
    int  low;
    bit  done;
    rd1D = a; rd2D = b; MultSgnD = sgn; MultStartD = 1'b1; MemtoRegD = 2'b10;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    step();
    MultStartD = 1'b0;
    low  = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (disturb && i == 4)  FlushE = 1'b1;
      if (disturb && i == 5)  FlushE = 1'b0;
      if (disturb && i == 10) MultStartD = 1'b1;
      if (disturb && i == 11) MultStartD = 1'b0;
      step();
      if (MultDoneE) done = 1'b1;
      else           low++;
    end
    check({tag, " busyCycles"}, 64'(low), 64'd32);
    check({tag, " LO"}, {32'd0, ALUMultOut}, {32'd0, prod[31:0]});
    MemtoRegD = 2'b11;
    step();
    check({tag, " HI"}, {32'd0, ALUMultOut}, {32'd0, prod[63:32]});
    MemtoRegD = 2'b00;
  endtask

  logic [2:0]  aluOps  [6] = '{3'b111, 3'b101, 3'b110, 3'b010, 3'b011, 3'b100};
  logic [31:0] aluExps [6] = '{32'h0, 32'h1, 32'h6, 32'h4, 32'hFFFFFFFA, 32'h0};

  initial begin
    rst = 1'b1;
    {MultStartD, MultSgnD, RegWriteD, MemWriteD, BranchD, RegDstD, jumpD} = '0;
    ALUSrcD = 2'b00; MemtoRegD = 2'b00; ALUControlD = 3'b000;
    RsD = 5'd0; RtD = 5'd0; RdD = 5'd0;
    rd1D = 32'd0; rd2D = 32'd0; SignImmD = 32'd0; UnsignedImmD = 32'd0;
    PCPlus4D = 32'd0; ALUOutM = 32'd0; ResultW = 32'd0;
    FlushE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    step(); step();

    // Reset state
    check("rst MultDoneE", 64'(MultDoneE), 64'd1);
    check("rst ctrls", 64'({jumpE, RegWriteE, MemWriteE, MultStartE, MemtoRegE}), 64'd0);
    check("rst regs", 64'({WriteRegE, RsE, RtE, RdE}), 64'd0);
    check("rst ALUMultOut", 64'(ALUMultOut), 64'd0);
    check("rst PCPlus4E", 64'(PCPlus4E), 64'd0);
    rst = 1'b0;

    // Forwarding
    rd1D = 32'd1; rd2D = 32'd2; ALUOutM = 32'd10; ResultW = 32'd20;
    ALUControlD = 3'b010; ALUSrcD = 2'b00;
    step();
    ForwardAE = 2'b10; #1;
    check("fwdA MEM", 64'(ALUMultOut), 64'd12);
    ForwardAE = 2'b01; #1;
    check("fwdA WB", 64'(ALUMultOut), 64'd22);
    ForwardAE = 2'b11; #1;
    check("fwdA 11", 64'(ALUMultOut), 64'd3);
    ForwardAE = 2'b00; ForwardBE = 2'b01; #1;
    check("fwdB WB data", 64'(WriteDataE), 64'd20);
    check("fwdB WB alu", 64'(ALUMultOut), 64'd21);
    ForwardBE = 2'b10; #1;
    check("fwdB MEM data", 64'(WriteDataE), 64'd10);
    ForwardBE = 2'b00;

    // ALU with sign-extended immediate, SrcA = 5, SrcB = 0xFFFFFFFF
    rd1D = 32'd5; SignImmD = 32'hFFFFFFFF; ALUSrcD = 2'b01;
    for (int i = 0; i < 6; i++) begin
      ALUControlD = aluOps[i];
      step();
      check($sformatf("alu op%b", aluOps[i]), 64'(ALUMultOut), 64'(aluExps[i]));
    end
    ALUSrcD = 2'b11; UnsignedImmD = 32'h00001234; ALUControlD = 3'b001;
    step();
    check("alu lui-or", 64'(ALUMultOut), 64'h12340005);
    ALUSrcD = 2'b10; ALUControlD = 3'b000;
    step();
    check("alu zimm-and", 64'(ALUMultOut), 64'h4);

    // Destination select and registered specifiers
    RsD = 5'd9; RtD = 5'd3; RdD = 5'd7; RegDstD = 1'b1;
    step();
    check("WriteReg Rd", 64'(WriteRegE), 64'd7);
    check("Rs/Rt/Rd E", 64'({RsE, RtE, RdE}), 64'({5'd9, 5'd3, 5'd7}));
    RegDstD = 1'b0;
    step();
    check("WriteReg Rt", 64'(WriteRegE), 64'd3);

    // Flush
    {RegWriteD, MemWriteD, BranchD, RegDstD, jumpD} = 5'b11111;
    MemtoRegD = 2'b01; PCPlus4D = 32'h00400010; rd2D = 32'h55;
    step();
    check("preflush ctrls", 64'({jumpE, RegWriteE, MemWriteE, MemtoRegE}), 64'b11101);
    check("preflush PC", 64'(PCPlus4E), 64'h00400010);
    FlushE = 1'b1;
    step();
    check("flush ctrls", 64'({jumpE, RegWriteE, MemWriteE, MultStartE, MemtoRegE}), 64'd0);
    check("flush regs", 64'({WriteRegE, RsE, RtE, RdE}), 64'd0);
    check("flush data", 64'({PCPlus4E, WriteDataE}), 64'd0);
    check("flush ALUMultOut", 64'(ALUMultOut), 64'd0);
    FlushE = 1'b0;
    {RegWriteD, MemWriteD, BranchD, RegDstD, jumpD} = 5'b00000;
    MemtoRegD = 2'b00; PCPlus4D = 32'd0; RsD = 5'd0; RtD = 5'd0; RdD = 5'd0;
    ALUSrcD = 2'b00;

    // Multiplies
    runMult("mulu 7x5",   32'd7,          32'd5,          1'b0, 64'd35,                  1'b0);
    runMult("mul -3x4",   32'hFFFFFFFD,   32'd4,          1'b1, 64'hFFFFFFFF_FFFFFFF4,   1'b0);
    runMult("mulu -3x4",  32'hFFFFFFFD,   32'd4,          1'b0, 64'h00000003_FFFFFFF4,   1'b0);
    runMult("mul -7x-6",  32'hFFFFFFF9,   32'hFFFFFFFA,   1'b1, 64'd42,                  1'b1);
    runMult("mulu max",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE_00000001,   1'b0);

    // Reset 10 cycles into a multiply
    rd1D = 32'd9; rd2D = 32'd9; MultSgnD = 1'b0; MultStartD = 1'b1;
    step();
    MultStartD = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("midmul busy", 64'(MultDoneE), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("midmul rst done", 64'(MultDoneE), 64'd1);
    #1 rst = 1'b0;
    MemtoRegD = 2'b10;
    step();
    check("midmul rst LO", 64'(ALUMultOut), 64'd0);
    MemtoRegD = 2'b11;
    step();
    check("midmul rst HI", 64'(ALUMultOut), 64'd0);
    check("midmul idle", 64'(MultDoneE), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
